// File: rtl/lcd_rgb_timing_gen.sv
// Parallel RGB LCD timing generator: early pixel request (registered), then one output stage
// that carries DE/HS/VS/RGB, so source data appears on the pins one cycle after its request.
module lcd_rgb_timing_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  input  logic [23:0] pix_data,
  output logic        frame_start,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        hs_s1;
  logic        vs_s1;

  logic h_act;
  logic v_act;
  logic h_in_sync;
  logic v_in_sync;

  assign h_act     = (h_cnt < H_ACT_END);
  assign v_act     = (v_cnt < V_ACT_END);
  assign h_in_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_in_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // Counters park at (0,0) while disabled so re-enable always starts a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs_s1       <= ~HS_POL;
      vs_s1       <= ~VS_POL;
    end else if (!en) begin
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      hs_s1       <= ~HS_POL;
      vs_s1       <= ~VS_POL;
    end else begin
      pix_req     <= h_act && v_act;
      frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
      hs_s1       <= h_in_sync ? HS_POL : ~HS_POL;
      vs_s1       <= v_in_sync ? VS_POL : ~VS_POL;
      if (h_act && v_act) begin
        pix_x <= h_cnt;
        pix_y <= v_cnt;
      end
    end
  end

  // Output stage delays syncs with DE; RGB is blanked whenever DE is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_de  <= 1'b0;
      lcd_rgb <= '0;
      lcd_hs  <= ~HS_POL;
      lcd_vs  <= ~VS_POL;
    end else begin
      lcd_de  <= pix_req;
      lcd_rgb <= pix_req ? pix_data : 24'h0;
      lcd_hs  <= hs_s1;
      lcd_vs  <= vs_s1;
    end
  end

endmodule
